// File: rtl/fifo_pkg.sv
// Shared types, default widths and wrapped pointer arithmetic for fifo_search.
package fifo_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, DONE = 2'd2} srch_state_t;

  localparam int DATA_WIDTH_DEF = 32;
  localparam int ADDR_WIDTH_DEF = 4;
  localparam int PTR_MAXW       = 16;

  // Callers truncate the result to the address width, which gives the modulo-depth wrap.
  function automatic logic [PTR_MAXW-1:0] ptr_add(input logic [PTR_MAXW-1:0] ptr,
                                                  input logic [PTR_MAXW-1:0] off);
    return ptr + off;
  endfunction
endpackage

// File: rtl/fifo_search_scan.sv
// Search engine: IDLE/SCAN/DONE FSM walking a snapshot of the FIFO oldest-first.
// FIFO_SEARCH_MASK_EN adds a per-bit compare mask latched with the request.
module fifo_search_scan
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  srch_req_i,
  input  logic [DATA_WIDTH-1:0] srch_key_i,
`ifdef FIFO_SEARCH_MASK_EN
  input  logic [DATA_WIDTH-1:0] srch_mask_i,
`endif
  input  logic [ADDR_WIDTH:0]   rd_ptr_i,
  input  logic [ADDR_WIDTH:0]   count_i,
  input  logic [DATA_WIDTH-1:0] scan_dat_i,
  output logic [ADDR_WIDTH-1:0] scan_addr_o,
  output logic                  pop_stall_o,
  output logic                  srch_busy_o,
  output logic                  srch_done_o,
  output logic                  srch_hit_o,
  output logic [ADDR_WIDTH:0]   srch_idx_o
);
  srch_state_t           state_q, state_d;
  logic [DATA_WIDTH-1:0] key_q, key_d;
  logic [ADDR_WIDTH:0]   base_q, base_d, len_q, len_d, off_q, off_d, idx_q, idx_d;
  logic                  hit_q, hit_d, match;

`ifdef FIFO_SEARCH_MASK_EN
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  assign match = ((scan_dat_i ^ key_q) & mask_q) == '0;
`else
  assign match = scan_dat_i == key_q;
`endif

  assign scan_addr_o = ADDR_WIDTH'(ptr_add(PTR_MAXW'(base_q), PTR_MAXW'(off_q)));
  assign srch_busy_o = state_q == SCAN;
  assign srch_done_o = state_q == DONE;
  assign pop_stall_o = srch_busy_o;
  assign srch_hit_o  = hit_q;
  assign srch_idx_o  = idx_q;

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    base_d  = base_q;
    len_d   = len_q;
    off_d   = off_q;
    hit_d   = hit_q;
    idx_d   = idx_q;
`ifdef FIFO_SEARCH_MASK_EN
    mask_d  = mask_q;
`endif
    case (state_q)
      IDLE: if (srch_req_i) begin
        key_d   = srch_key_i;
`ifdef FIFO_SEARCH_MASK_EN
        mask_d  = srch_mask_i;
`endif
        base_d  = rd_ptr_i;
        len_d   = count_i;
        off_d   = '0;
        hit_d   = 1'b0;
        idx_d   = '0;
        state_d = (count_i == '0) ? DONE : SCAN;
      end
      SCAN: begin
        if (match) begin
          hit_d   = 1'b1;
          idx_d   = off_q;
          state_d = DONE;
        end else if (off_q == len_q - (ADDR_WIDTH+1)'(1)) begin
          state_d = DONE;
        end else begin
          off_d = off_q + (ADDR_WIDTH+1)'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      key_q   <= '0;
      base_q  <= '0;
      len_q   <= '0;
      off_q   <= '0;
      hit_q   <= 1'b0;
      idx_q   <= '0;
`ifdef FIFO_SEARCH_MASK_EN
      mask_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      base_q  <= base_d;
      len_q   <= len_d;
      off_q   <= off_d;
      hit_q   <= hit_d;
      idx_q   <= idx_d;
`ifdef FIFO_SEARCH_MASK_EN
      mask_q  <= mask_d;
`endif
    end
  end
endmodule

// File: rtl/fifo_search.sv
// Synchronous FIFO with occupancy flags and an oldest-first content search.
// FIFO_SEARCH_MASK_EN adds the srch_mask input for masked key compares.
module fifo_search
  import fifo_pkg::*;
#(
  parameter int DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH    = ADDR_WIDTH_DEF,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wren,
  input  logic [DATA_WIDTH-1:0] wdat,
  input  logic                  rden,
  output logic [DATA_WIDTH-1:0] rdat,
  output logic                  rvld,
  output logic                  full,
  output logic                  empty,
  output logic                  afull,
  output logic                  aempty,
  output logic [ADDR_WIDTH:0]   count,
  input  logic                  srch_req,
  input  logic [DATA_WIDTH-1:0] srch_key,
`ifdef FIFO_SEARCH_MASK_EN
  input  logic [DATA_WIDTH-1:0] srch_mask,
`endif
  output logic                  srch_busy,
  output logic                  srch_done,
  output logic                  srch_hit,
  output logic [ADDR_WIDTH:0]   srch_idx
);
  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [DATA_WIDTH-1:0] rdat_q, rdat_d;
  logic                  rvld_q, rvld_d;
  logic [ADDR_WIDTH-1:0] scan_addr;
  logic                  pop_stall, push_ok, pop_ok;

  // Pointers carry one extra wrap bit so full and empty are distinguishable.
  assign empty  = wr_ptr_q == rd_ptr_q;
  assign full   = (wr_ptr_q[ADDR_WIDTH] != rd_ptr_q[ADDR_WIDTH]) &&
                  (wr_ptr_q[ADDR_WIDTH-1:0] == rd_ptr_q[ADDR_WIDTH-1:0]);
  assign count  = wr_ptr_q - rd_ptr_q;
  assign afull  = count >= (ADDR_WIDTH+1)'(AFULL_THRESH);
  assign aempty = count <= (ADDR_WIDTH+1)'(AEMPTY_THRESH);

  assign push_ok  = wren & ~full;
  assign pop_ok   = rden & ~empty & ~pop_stall;
  assign wr_ptr_d = push_ok ? wr_ptr_q + (ADDR_WIDTH+1)'(1) : wr_ptr_q;
  assign rd_ptr_d = pop_ok  ? rd_ptr_q + (ADDR_WIDTH+1)'(1) : rd_ptr_q;
  assign rdat_d   = pop_ok  ? mem_q[rd_ptr_q[ADDR_WIDTH-1:0]] : '0;
  assign rvld_d   = pop_ok;
  assign rdat     = rdat_q;
  assign rvld     = rvld_q;

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q[ADDR_WIDTH-1:0]] <= wdat;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      rdat_q   <= '0;
      rvld_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      rdat_q   <= rdat_d;
      rvld_q   <= rvld_d;
    end
  end

  fifo_search_scan #(.DATA_WIDTH(DATA_WIDTH), .ADDR_WIDTH(ADDR_WIDTH)) u_scan (
    .clk         (clk),
    .rst         (rst),
    .srch_req_i  (srch_req),
    .srch_key_i  (srch_key),
`ifdef FIFO_SEARCH_MASK_EN
    .srch_mask_i (srch_mask),
`endif
    .rd_ptr_i    (rd_ptr_q),
    .count_i     (count),
    .scan_dat_i  (mem_q[scan_addr]),
    .scan_addr_o (scan_addr),
    .pop_stall_o (pop_stall),
    .srch_busy_o (srch_busy),
    .srch_done_o (srch_done),
    .srch_hit_o  (srch_hit),
    .srch_idx_o  (srch_idx)
  );
endmodule
